// File: rtl/pregfile_param_scb.sv
// Parametrised multi-port physical register file with a busy-bit scoreboard.
// Rename allocates entries busy, writeback clears them; reads bypass same-cycle writes.
module pregfile_param_scb #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned PREG_NUM  = 64,
   parameter int unsigned NUM_RD    = 4,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned READ_LAT  = 0
) (
   input  logic                                    clock,
   input  logic                                    reset_n,
   input  logic [NUM_WR-1:0]                       wren,
   input  logic [NUM_WR*$clog2(PREG_NUM)-1:0]      waddr,
   input  logic [NUM_WR*DATA_W-1:0]                wdata,
   input  logic [NUM_RD-1:0]                       rden,
   input  logic [NUM_RD*$clog2(PREG_NUM)-1:0]      raddr,
   output logic [NUM_RD*DATA_W-1:0]                rdata,
   output logic [NUM_RD-1:0]                       rready,
   input  logic [NUM_ALLOC-1:0]                    alloc_en,
   input  logic [NUM_ALLOC*$clog2(PREG_NUM)-1:0]   alloc_addr,
   input  logic                                    flush,
   output logic                                    wr_conflict,
   output logic [$clog2(PREG_NUM+1)-1:0]           busy_count
);

   localparam int unsigned ADDR_W = $clog2(PREG_NUM);
   localparam int unsigned CNT_W  = $clog2(PREG_NUM+1);

   logic [DATA_W-1:0]        mem [PREG_NUM];
   logic [PREG_NUM-1:0]      busy;
   logic [PREG_NUM-1:0]      busy_nxt;
   logic [CNT_W-1:0]         busy_cnt_nxt;
   logic                     conflict_c;
   logic [NUM_RD*DATA_W-1:0] rdata_c;
   logic [NUM_RD-1:0]        rready_c;

   // Array write; later ports overwrite earlier ones, entry 0 is never written
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PREG_NUM; i++) mem[i] <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wren[k] && waddr[k*ADDR_W +: ADDR_W] != '0)
               mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Two enabled writes to the same nonzero address
   always_comb begin
      conflict_c = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
         for (int m = k + 1; m < NUM_WR; m++) begin
            if (wren[k] && wren[m] &&
                waddr[k*ADDR_W +: ADDR_W] == waddr[m*ADDR_W +: ADDR_W] &&
                waddr[k*ADDR_W +: ADDR_W] != '0)
               conflict_c = 1'b1;
         end
      end
   end

   // Busy next state: writeback clears, alloc overrides, flush overrides all
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wren[k] && waddr[k*ADDR_W +: ADDR_W] != '0)
            busy_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
         if (alloc_en[a] && alloc_addr[a*ADDR_W +: ADDR_W] != '0)
            busy_nxt[alloc_addr[a*ADDR_W +: ADDR_W]] = 1'b1;
      end
      if (flush) busy_nxt = '0;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      busy_cnt_nxt = '0;
      for (int i = 0; i < PREG_NUM; i++)
         busy_cnt_nxt = busy_cnt_nxt + CNT_W'(busy_nxt[i]);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy        <= '0;
         busy_count  <= '0;
         wr_conflict <= 1'b0;
      end else begin
         busy        <= busy_nxt;
         busy_count  <= busy_cnt_nxt;
         wr_conflict <= conflict_c;
      end
   end

   // Read with write bypass; highest-index matching write port supplies data
   always_comb begin : read_path
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] dat;
      logic              hit;
      rdata_c  = '0;
      rready_c = '0;
      ra       = '0;
      dat      = '0;
      hit      = 1'b0;
      for (int j = 0; j < NUM_RD; j++) begin
         ra  = raddr[j*ADDR_W +: ADDR_W];
         dat = mem[ra];
         hit = 1'b0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (wren[k] && waddr[k*ADDR_W +: ADDR_W] == ra && ra != '0) begin
               dat = wdata[k*DATA_W +: DATA_W];
               hit = 1'b1;
            end
         end
         if (rden[j]) begin
            rdata_c[j*DATA_W +: DATA_W] = dat;
            rready_c[j] = (ra == '0) | ~busy[ra] | hit;
         end
      end
   end

   if (READ_LAT == 0) begin : g_comb_read
      assign rdata  = rdata_c;
      assign rready = rready_c;
   end else begin : g_reg_read
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            rdata  <= '0;
            rready <= '0;
         end else begin
            rdata  <= rdata_c;
            rready <= rready_c;
         end
      end
   end

endmodule
